instr_encoder_loader: RTL
=========================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the instruction-memory address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, which begins a load session.
REQ-005 SHALL have port base_addr, input, ADDR_W, the first write address, sampled on start.
REQ-006 SHALL have port in_valid, input, 1, marking the field tuple as valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a tuple this cycle.
REQ-008 SHALL have port fmt, input, 2, the format code: 0=R, 1=I, 2=J, 3=reserved.
REQ-009 SHALL have ports opcode and funct, input, 6 each; and rs, rt, rd and shamt, input, 5 each.
REQ-010 SHALL have ports imm, input, 16; and jump_addr, input, 26.
REQ-011 SHALL have port last, input, 1, marking the tuple as the final instruction of the session.
REQ-012 SHALL have ports mem_we, output, 1; mem_addr, output, ADDR_W; and mem_wdata, output, 32, together forming the instruction-memory write port.
REQ-013 SHALL have ports busy, output, 1; done, output, 1 (one-cycle pulse); error, output, 1 (sticky per session); and count, output, ADDR_W+1 (words written).

Function
REQ-014 SHALL implement states IDLE, ACCEPT, WRITE and DONE.
REQ-015 In IDLE, start SHALL load addr from base_addr, clear count and error, and go to ACCEPT; start outside IDLE SHALL be ignored.
REQ-016 in_ready SHALL be 1 only in ACCEPT; a handshake occurs when in_valid && in_ready.
REQ-017 On a handshake, the block SHALL register the encoded word and last, then go to WRITE.
REQ-018 The encoded word SHALL be formed per format:
- R: {opcode,rs,rt,rd,shamt,funct}
- I: {opcode,rs,rt,imm}
- J: {opcode,jump_addr}
REQ-019 If fmt=3, the word SHALL be 32'h00000000 and error SHALL be set to 1.
REQ-020 In WRITE, mem_we SHALL be 1 for exactly one cycle with mem_addr=addr and mem_wdata=the registered word; addr SHALL increment modulo DEPTH (wraps) and count SHALL increment.
REQ-021 After WRITE, the block SHALL go to DONE if last was set or count reaches DEPTH; otherwise it SHALL return to ACCEPT.
REQ-022 If count reaches DEPTH without last, error SHALL be set to 1.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Throughput SHALL be one word per 2 cycles; latency from handshake to mem_we SHALL be 1 cycle.
REQ-026 Unused fields for a given format SHALL be ignored.
REQ-027 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-028 rst SHALL force state IDLE and set in_ready, mem_we, busy, done and error to 0, and mem_addr, mem_wdata and count to 0.
REQ-029 rst mid-session SHALL abort the session with no further write; an rst in the same cycle as start SHALL take priority.

Structure
REQ-030 A shared package SHALL hold the format codes (FMT_R, FMT_I, FMT_J, FMT_RSVD), the state encoding, and the field widths.
REQ-031 A combinational sub-module, instruction_encoder, SHALL map fmt plus fields to the 32-bit word; the FSM and counters SHALL live in the top level.

Verification
REQ-032 R-format: start, base 0x10; tuple fmt=0, op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, last=1 -> one write, addr 0x10, data 0x00221820; done pulse; count=1; error=0.
REQ-033 Mixed formats: I op=8, rs=0, rt=8, imm=5 -> 0x20080005; J op=2, jump_addr=0x10 (last) -> 0x08000010; writes at consecutive addresses.
REQ-034 Wrap-around: base 0xFE, three tuples -> writes at 0xFE, 0xFF, 0x00; count=3.
REQ-035 Full: 256 tuples, none with last -> 256 writes, error=1, done after the 256th write; in_ready stays 0 afterwards.
REQ-036 Reserved format plus reset: fmt=3 -> data 0x00000000 with error=1; then rst during WRITE of the next tuple -> no mem_we and all outputs 0 the following cycle.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: field widths,
// instruction format codes and the loader FSM state encoding.
package instr_encoder_loader_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int IMM_W    = 16;
  localparam int JADDR_W  = 26;
  localparam int FMT_W    = 2;
  localparam int WORD_W   = 32;

  typedef enum logic [FMT_W-1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_J    = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/instruction_encoder.sv
// Combinational packer: maps a format code plus instruction fields onto a
// 32-bit instruction word. Fields not used by the selected format are ignored.
module instruction_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [FMT_W-1:0]    fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [IMM_W-1:0]    imm,
  input  logic [JADDR_W-1:0]  jump_addr,
  output logic [WORD_W-1:0]   word,
  output logic                rsvd
);

  // Select the packing for the requested format; reserved yields a zero word.
  always_comb begin
    word = '0;
    rsvd = 1'b0;
    case (fmt_e'(fmt))
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, jump_addr};
      default: rsvd = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction loader: accepts field tuples over a valid/ready handshake,
// encodes them and writes one word per two cycles into instruction memory
// starting at base_addr, wrapping at the end of the address space.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet
// S_ACCEPT | in_ready high, waiting for a valid tuple
// S_WRITE  | mem_we high for one cycle, addr/count advance
// S_DONE   | done pulse, then back to S_IDLE
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FMT_W-1:0]    fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [IMM_W-1:0]    imm,
  input  logic [JADDR_W-1:0]  jump_addr,
  input  logic                last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                error_q, error_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [WORD_W-1:0]   enc_word;
  logic                enc_rsvd;
  logic [ADDR_W:0]     count_inc;

  instruction_encoder u_encoder (
    .fmt       (fmt),
    .opcode    (opcode),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .jump_addr (jump_addr),
    .word      (enc_word),
    .rsvd      (enc_rsvd)
  );

  assign count_inc = count_q + (ADDR_W + 1)'(1);

  // Next-state and datapath update for the load session.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    error_d     = error_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          count_d = '0;
          error_d = 1'b0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          // The write port registers double as the word/address holding
          // registers, so they keep their values once mem_we drops.
          mem_addr_d  = addr_q;
          mem_wdata_d = enc_word;
          last_d      = last;
          if (enc_rsvd) error_d = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_inc;
        if (last_q || (count_inc == COUNT_FULL)) begin
          if (!last_q) error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      last_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A reset arriving during the write cycle suppresses that write.
  always_comb begin
    in_ready  = (state_q == S_ACCEPT);
    mem_we    = (state_q == S_WRITE) && !rst;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    error     = error_q;
    count     = count_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule
